// File: rtl/register_file_param_if.sv
// rtl/register_file_param_if.sv - decode/writeback bus of the parametrised register file
interface register_file_param_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] i_reg_read_0;
    logic [ADDR_W-1:0] i_reg_read_1;
    logic [ADDR_W-1:0] i_reg_write;
    logic [WIDTH-1:0]  i_port_write;
    logic              i_write_enable;
    logic              i_reserve_enable;
    logic [ADDR_W-1:0] i_reg_reserve;
    logic [WIDTH-1:0]  o_port_read_0;
    logic [WIDTH-1:0]  o_port_read_1;
    logic              o_busy_0;
    logic              o_busy_1;

    modport master (
        output i_reg_read_0, i_reg_read_1, i_reg_write, i_port_write,
        output i_write_enable, i_reserve_enable, i_reg_reserve,
        input  o_port_read_0, o_port_read_1, o_busy_0, o_busy_1
    );

    modport slave (
        input  i_reg_read_0, i_reg_read_1, i_reg_write, i_port_write,
        input  i_write_enable, i_reserve_enable, i_reg_reserve,
        output o_port_read_0, o_port_read_1, o_busy_0, o_busy_1
    );
endinterface

// File: rtl/register_file_param.sv
// rtl/register_file_param.sv - DEPTH x WIDTH register file, two read ports, busy scoreboard
module register_file_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter bit BYPASS   = 1'b0,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    register_file_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_write_ok;
    logic              w_reserve_ok;
    logic [DEPTH-1:0]  w_busy_next;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [WIDTH-1:0]  w_rdata [2];
    logic              w_rbusy [2];

    // Register 0 swallows writes and reserves when it is hardwired to zero.
    assign w_write_ok   = bus.i_write_enable &&
                          !(ZERO_REG && (bus.i_reg_write == '0));
    assign w_reserve_ok = bus.i_reserve_enable &&
                          !(ZERO_REG && (bus.i_reg_reserve == '0));

    // Retire then reserve: a new producer claiming the same register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_write_ok)
            w_busy_next[bus.i_reg_write] = 1'b0;
        if (w_reserve_ok)
            w_busy_next[bus.i_reg_reserve] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_write_ok)
                r_regs[bus.i_reg_write] <= bus.i_port_write;
            r_busy <= w_busy_next;
        end
    end

    assign w_raddr[0] = bus.i_reg_read_0;
    assign w_raddr[1] = bus.i_reg_read_1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            w_rbusy[p] = r_busy[w_raddr[p]];
            if (BYPASS && bus.i_write_enable && (w_raddr[p] == bus.i_reg_write)) begin
                w_rdata[p] = bus.i_port_write;
                w_rbusy[p] = bus.i_reserve_enable && (bus.i_reg_reserve == w_raddr[p]);
            end
            if (ZERO_REG && (w_raddr[p] == '0)) begin
                w_rdata[p] = '0;
                w_rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.o_port_read_0 = w_rdata[0];
    assign bus.o_port_read_1 = w_rdata[1];
    assign bus.o_busy_0      = w_rbusy[0];
    assign bus.o_busy_1      = w_rbusy[1];
endmodule

// File: tb/tb_register_file_param.sv
// tb/tb_register_file_param.sv - directed vector bench for register_file_param
module tb_register_file_param;
    logic       clk;
    logic       rst;
    logic [2:0] t_rd0, t_rd1, t_wa, t_rr;
    logic [7:0] t_wd;
    logic       t_we, t_re;
    int         n_checks;
    int         n_fail;

    register_file_param_if #(.WIDTH(8), .ADDR_W(3)) if_a ();
    register_file_param_if #(.WIDTH(8), .ADDR_W(3)) if_b ();
    register_file_param_if #(.WIDTH(8), .ADDR_W(3)) if_c ();

    assign if_a.i_reg_read_0 = t_rd0;  assign if_b.i_reg_read_0 = t_rd0;  assign if_c.i_reg_read_0 = t_rd0;
    assign if_a.i_reg_read_1 = t_rd1;  assign if_b.i_reg_read_1 = t_rd1;  assign if_c.i_reg_read_1 = t_rd1;
    assign if_a.i_reg_write  = t_wa;   assign if_b.i_reg_write  = t_wa;   assign if_c.i_reg_write  = t_wa;
    assign if_a.i_port_write = t_wd;   assign if_b.i_port_write = t_wd;   assign if_c.i_port_write = t_wd;
    assign if_a.i_write_enable = t_we; assign if_b.i_write_enable = t_we; assign if_c.i_write_enable = t_we;
    assign if_a.i_reserve_enable = t_re; assign if_b.i_reserve_enable = t_re; assign if_c.i_reserve_enable = t_re;
    assign if_a.i_reg_reserve = t_rr;  assign if_b.i_reg_reserve = t_rr;  assign if_c.i_reg_reserve = t_rr;

    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0))
        u_a (.i_clk(clk), .i_reset(rst), .bus(if_a.slave));
    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0))
        u_b (.i_clk(clk), .i_reset(rst), .bus(if_b.slave));
    register_file_param #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b1))
        u_c (.i_clk(clk), .i_reset(rst), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, we, re, chk;
        logic [2:0] wa, rr, ra0, ra1;
        logic [7:0] wd, d0, d1;
        logic       b0, b1;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic r, input logic we, input logic [2:0] wa,
                                input logic [7:0] wd, input logic re, input logic [2:0] rr,
                                input logic [2:0] ra0, input logic [2:0] ra1, input logic chk,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic b0, input logic b1);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.rr = rr;
        v.ra0 = ra0; v.ra1 = ra1; v.chk = chk; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] rr, input logic [2:0] ra0, input logic [2:0] ra1);
        rst = r; t_we = we; t_wa = wa; t_wd = wd; t_re = re; t_rr = rr; t_rd0 = ra0; t_rd1 = ra1;
        #3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Vectors for the BYPASS=0 / ZERO_REG=0 instance; d0/b0 sampled before the edge.
        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(0, 0, 0, 8'h00, 0, 0, 3, 7, 1, 8'h00, 8'h00, 0, 0);
        vecs[2]  = mk(0, 1, 3, 8'hA5, 0, 0, 3, 3, 1, 8'h00, 8'h00, 0, 0);
        vecs[3]  = mk(0, 1, 7, 8'h3C, 0, 0, 3, 7, 1, 8'hA5, 8'h00, 0, 0);
        vecs[4]  = mk(0, 0, 0, 8'h00, 0, 0, 3, 7, 1, 8'hA5, 8'h3C, 0, 0);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1, 5, 5, 5, 1, 8'h00, 8'h00, 0, 0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 0, 0, 5, 3, 1, 8'h00, 8'hA5, 1, 0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 1, 5, 5, 5, 1, 8'h00, 8'h00, 1, 1);
        vecs[8]  = mk(0, 1, 5, 8'h11, 0, 0, 5, 5, 1, 8'h00, 8'h00, 1, 1);
        vecs[9]  = mk(0, 0, 0, 8'h00, 0, 0, 5, 5, 1, 8'h11, 8'h11, 0, 0);
        vecs[10] = mk(0, 1, 5, 8'h22, 1, 5, 5, 5, 1, 8'h11, 8'h11, 0, 0);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 0, 5, 5, 1, 8'h22, 8'h22, 1, 1);
        vecs[12] = mk(0, 1, 5, 8'h33, 0, 0, 5, 5, 1, 8'h22, 8'h22, 1, 1);
        vecs[13] = mk(0, 1, 2, 8'h44, 0, 0, 2, 5, 1, 8'h00, 8'h33, 0, 0);
        vecs[14] = mk(0, 0, 0, 8'h00, 0, 0, 2, 2, 1, 8'h44, 8'h44, 0, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 1, 1, 1, 6, 1, 8'h00, 8'h00, 0, 0);
        vecs[16] = mk(0, 0, 0, 8'h00, 1, 6, 1, 6, 1, 8'h00, 8'h00, 1, 0);
        vecs[17] = mk(1, 1, 1, 8'h77, 0, 0, 1, 6, 1, 8'h00, 8'h00, 1, 1);
        vecs[18] = mk(0, 0, 0, 8'h00, 0, 0, 1, 6, 1, 8'h00, 8'h00, 0, 0);
        vecs[19] = mk(0, 0, 0, 8'h00, 0, 0, 3, 7, 1, 8'h00, 8'h00, 0, 0);

        // Random writes and reserves, then reset clears every index.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 3'(i), 8'($urandom_range(1, 255)), 1, 3'($urandom_range(0, 7)), 0, 0);
            step();
        end
        drive(1, 0, 0, 8'h00, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 8'h00, 0, 0, 3'(i), 3'(7 - i));
            chk($sformatf("rst d0 r%0d", i), if_a.o_port_read_0, 8'h00);
            chk($sformatf("rst d1 r%0d", 7 - i), if_a.o_port_read_1, 8'h00);
            chk($sformatf("rst b0 r%0d", i), {7'd0, if_a.o_busy_0}, 8'h00);
            chk($sformatf("rst b1 r%0d", 7 - i), {7'd0, if_a.o_busy_1}, 8'h00);
            step();
        end

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re, vecs[i].rr, vecs[i].ra0, vecs[i].ra1);
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d d0", i), if_a.o_port_read_0, vecs[i].d0);
                chk($sformatf("vec%0d d1", i), if_a.o_port_read_1, vecs[i].d1);
                chk($sformatf("vec%0d b0", i), {7'd0, if_a.o_busy_0}, {7'd0, vecs[i].b0});
                chk($sformatf("vec%0d b1", i), {7'd0, if_a.o_busy_1}, {7'd0, vecs[i].b1});
            end
            step();
        end

        // Bypass instance.
        drive(1, 0, 0, 8'h00, 0, 0, 0, 0);
        step();
        drive(0, 1, 2, 8'h5A, 0, 0, 2, 2);
        chk("byp d0 same cycle", if_b.o_port_read_0, 8'h5A);
        chk("byp d1 same cycle", if_b.o_port_read_1, 8'h5A);
        chk("byp b0 same cycle", {7'd0, if_b.o_busy_0}, 8'h00);
        chk("nobyp d0 same cycle", if_a.o_port_read_0, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 0, 0, 2, 2);
        chk("byp d0 stored", if_b.o_port_read_0, 8'h5A);
        chk("byp d1 stored", if_b.o_port_read_1, 8'h5A);
        step();
        drive(0, 1, 4, 8'h66, 1, 4, 4, 4);
        chk("byp wr+rsv d0", if_b.o_port_read_0, 8'h66);
        chk("byp wr+rsv b1", {7'd0, if_b.o_busy_1}, 8'h01);
        step();
        drive(0, 0, 0, 8'h00, 0, 0, 4, 4);
        chk("byp wr+rsv next d0", if_b.o_port_read_0, 8'h66);
        chk("byp wr+rsv next b0", {7'd0, if_b.o_busy_0}, 8'h01);
        step();
        drive(0, 1, 4, 8'h77, 0, 0, 4, 2);
        chk("byp retire d0", if_b.o_port_read_0, 8'h77);
        chk("byp retire b0", {7'd0, if_b.o_busy_0}, 8'h00);
        chk("byp retire d1", if_b.o_port_read_1, 8'h5A);
        chk("nobyp retire b0", {7'd0, if_a.o_busy_0}, 8'h01);
        chk("nobyp retire d0", if_a.o_port_read_0, 8'h66);
        step();

        // Hardwired zero register (with bypass enabled).
        drive(1, 0, 0, 8'h00, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 8'hFF, 1, 0, 0, 0);
        chk("zero d0 bypass", if_c.o_port_read_0, 8'h00);
        chk("zero b1 bypass", {7'd0, if_c.o_busy_1}, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
        chk("zero d0 next", if_c.o_port_read_0, 8'h00);
        chk("zero b0 next", {7'd0, if_c.o_busy_0}, 8'h00);
        chk("plain r0 d0", if_a.o_port_read_0, 8'hFF);
        chk("plain r0 b0", {7'd0, if_a.o_busy_0}, 8'h01);
        step();
        drive(0, 1, 1, 8'hFF, 0, 0, 1, 0);
        chk("zero r1 bypass", if_c.o_port_read_0, 8'hFF);
        chk("zero r0 port1", if_c.o_port_read_1, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 0, 0, 1, 1);
        chk("zero r1 stored", if_c.o_port_read_1, 8'hFF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
